regfile_mp: RTL and testbench

Parametrised multi-read-port general-purpose register file for the pipelined core, succeeding the single-cycle 2-read/1-write register file. Adds:
- N read ports
- write-to-read bypass
- a per-register busy scoreboard for pipeline hazard detection
- a sequential post-reset clear engine that zeroes the array one entry per cycle

Sits between decode (reads, issue) and writeback (write).

---
 rtl/regfile_mp_pkg.sv | 8 +
 rtl/regfile_scoreboard.sv | 36 +++
 rtl/regfile_mp.sv | 57 +++++
 tb/tb_regfile_mp.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared defaults, zero word and clear/run state encoding for the register file
package regfile_mp_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF = $clog2(NREGS_DEF);
  localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with issue-over-writeback priority and per-port lookup
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW = $clog2(NREGS),
  parameter int NRD = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_set,
  input  logic [AW-1:0]   i_set_rd,
  input  logic            i_clr,
  input  logic [AW-1:0]   i_clr_rd,
  input  logic [NRD-1:0]  i_re,
  input  logic [NRD*AW-1:0] i_raddr,
  output logic [NRD-1:0]  o_rbusy
);
  logic [NREGS-1:0] r_busy, w_busy_nx;
  // Set is applied after clear so a re-issue of the register being written back stays busy.
  always_comb begin
    w_busy_nx = r_busy;
    if (i_clr) w_busy_nx[i_clr_rd] = 1'b0;
    if (i_set) w_busy_nx[i_set_rd] = 1'b1;
    w_busy_nx[0] = 1'b0;
  end
  always_ff @(posedge clk) r_busy <= rst ? '0 : w_busy_nx;
  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [AW-1:0] w_ra;
    logic w_fwd_clr;
    assign w_ra = i_raddr[i*AW +: AW];
    assign w_fwd_clr = BYPASS && i_clr && i_clr_rd == w_ra && !(i_set && i_set_rd == w_ra);
    assign o_rbusy[i] = i_re[i] && w_ra != '0 && r_busy[w_ra] && !w_fwd_clr;
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: N-read-port register file with write bypass, busy scoreboard and post-reset clear engine
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW = $clog2(NREGS),
  parameter int NRD = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [NRD-1:0]    re,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd
);
  state_t r_state, w_state_nx;
  logic [AW-1:0] r_cnt;
  logic [XLEN-1:0] r_regs [NREGS];
  logic w_run, w_wr;
  assign w_run = r_state == RUN;
  assign init_done = w_run;
  assign w_wr = w_run && !rst && we && waddr != '0;
  always_comb w_state_nx = rst ? CLEAR : (r_state == CLEAR && r_cnt == AW'(NREGS - 1)) ? RUN : r_state;
  always_ff @(posedge clk) begin
    r_state <= w_state_nx;
    r_cnt <= (rst || w_run) ? '0 : r_cnt + 1'b1;
  end
  // The array has no reset; the clear engine zeroes one entry per cycle instead.
  always_ff @(posedge clk)
    if (!rst && !w_run) r_regs[r_cnt] <= '0;
    else if (w_wr) r_regs[waddr] <= wdata;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = raddr[i*AW +: AW];
    assign rdata[i*XLEN +: XLEN] = (!w_run || w_ra == '0 || !re[i]) ? XLEN'(ZERO_WORD)
                                 : (BYPASS && we && waddr == w_ra) ? wdata : r_regs[w_ra];
  end
  regfile_scoreboard #(.NREGS(NREGS), .AW(AW), .NRD(NRD), .BYPASS(BYPASS)) u_sb (
    .clk(clk),
    .rst(rst),
    .i_set(w_run && iss_valid),
    .i_set_rd(iss_rd),
    .i_clr(w_run && we),
    .i_clr_rd(waddr),
    .i_re(re),
    .i_raddr(raddr),
    .o_rbusy(rbusy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for default and 16x64/4-port/no-bypass configurations
module tb_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, init_done, we, iss_valid;
  logic [4:0] waddr, iss_rd;
  logic [31:0] wdata;
  logic [1:0] re, rbusy;
  logic [9:0] raddr;
  logic [63:0] rdata;
  logic b_rst, b_init_done, b_we, b_iss_valid;
  logic [3:0] b_waddr, b_iss_rd, b_re, b_rbusy;
  logic [63:0] b_wdata;
  logic [15:0] b_raddr;
  logic [255:0] b_rdata;
  regfile_mp u0 (
    .clk(clk), .rst(rst), .init_done(init_done), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .iss_valid(iss_valid), .iss_rd(iss_rd)
  );
  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4), .BYPASS(1'b0)) u1 (
    .clk(clk), .rst(b_rst), .init_done(b_init_done), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .re(b_re), .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy), .iss_valid(b_iss_valid), .iss_rd(b_iss_rd)
  );
  logic [63:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] bv [4];
  logic [3:0] ba [4];
  task automatic push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask
  task automatic pop_cmp(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s: observed=%h, expected queue empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; we = 0; waddr = 0; wdata = 0; re = 0; raddr = 0; iss_valid = 0; iss_rd = 0;
    b_rst = 1; b_we = 0; b_waddr = 0; b_wdata = 0; b_re = 0; b_raddr = 0; b_iss_valid = 0; b_iss_rd = 0;
    bv = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002, 64'h3333_0000_0000_0003, 64'hFFFF_0000_0000_000F};
    ba = '{4'd1, 4'd2, 4'd3, 4'd15};
    tick;
    tick;
    rst = 0; b_rst = 0;
    we = 1; waddr = 5'd6; wdata = 32'hFFFF_FFFF; iss_valid = 1; iss_rd = 5'd4;
    re = 2'b11; raddr = {5'd4, 5'd6};
    for (int k = 0; k < 32; k++) begin
      #1;
      push(0); pop_cmp("init_done_clear", {63'd0, init_done});
      if (k == 0 || k == 31) begin
        push(0); push(0);
        pop_cmp("rdata_clear", rdata[31:0]);
        pop_cmp("rbusy_clear", {63'd0, rbusy[1]});
      end
      if (k == 15) begin push(0); pop_cmp("b_init_done_15", {63'd0, b_init_done}); end
      if (k == 16) begin push(1); pop_cmp("b_init_done_16", {63'd0, b_init_done}); end
      tick;
    end
    we = 0; iss_valid = 0;
    #1;
    push(1); push(0); push(0);
    pop_cmp("init_done_run", {63'd0, init_done});
    pop_cmp("clear_ignores_we", rdata[31:0]);
    pop_cmp("clear_ignores_iss", {63'd0, rbusy[1]});
    we = 1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; re = 0;
    tick;
    we = 0; raddr[4:0] = 5'd5; re = 2'b01;
    #1; push(32'hDEAD_BEEF); pop_cmp("rd_x5", rdata[31:0]);
    re = 0;
    #1; push(0); pop_cmp("re_gate", rdata[31:0]);
    re = 2'b01; we = 1; waddr = 5'd0; wdata = 32'h1234; raddr[4:0] = 5'd0;
    #1; push(0); pop_cmp("x0_same_cycle", rdata[31:0]);
    tick;
    we = 0;
    #1; push(0); pop_cmp("x0_after", rdata[31:0]);
    we = 1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; raddr[9:5] = 5'd7; re = 2'b10;
    #1; push(32'hA5A5_A5A5); pop_cmp("bypass", rdata[63:32]);
    tick;
    we = 0;
    #1; push(32'hA5A5_A5A5); pop_cmp("rd_x7", rdata[63:32]);
    raddr[9:5] = 5'd9; iss_valid = 1; iss_rd = 5'd9;
    #1; push(0); pop_cmp("busy_pre", {63'd0, rbusy[1]});
    tick;
    iss_valid = 0;
    #1; push(1); pop_cmp("busy_set", {63'd0, rbusy[1]});
    we = 1; waddr = 5'd9; wdata = 32'd99;
    #1; push(0); pop_cmp("busy_bypass_clr", {63'd0, rbusy[1]});
    tick;
    we = 0;
    #1; push(0); pop_cmp("busy_clr", {63'd0, rbusy[1]});
    iss_valid = 1; iss_rd = 5'd9;
    tick;
    we = 1; waddr = 5'd9;
    #1; push(1); pop_cmp("busy_same_reg_now", {63'd0, rbusy[1]});
    tick;
    we = 0; iss_valid = 0;
    #1; push(1); pop_cmp("busy_same_reg_after", {63'd0, rbusy[1]});
    iss_valid = 1; iss_rd = 5'd10; we = 1; waddr = 5'd9; raddr[4:0] = 5'd10; re = 2'b11;
    tick;
    iss_valid = 0; we = 0;
    #1; push(1); push(0);
    pop_cmp("busy_x10", {63'd0, rbusy[0]});
    pop_cmp("busy_x9", {63'd0, rbusy[1]});
    iss_valid = 1; iss_rd = 5'd0; raddr[4:0] = 5'd0;
    tick;
    iss_valid = 0;
    #1; push(0); pop_cmp("busy_x0", {63'd0, rbusy[0]});
    we = 1; waddr = 5'd3; wdata = 32'h55;
    tick;
    we = 0; raddr[4:0] = 5'd3; re = 2'b01;
    #1; push(32'h55); pop_cmp("rd_x3", rdata[31:0]);
    rst = 1;
    tick;
    rst = 0;
    repeat (10) tick;
    push(0); pop_cmp("init_done_mid_clear", {63'd0, init_done});
    rst = 1;
    tick;
    rst = 0;
    for (int k = 0; k < 32; k++) begin
      #1;
      push(0); pop_cmp("init_done_reclear", {63'd0, init_done});
      tick;
    end
    raddr[9:5] = 5'd10; re = 2'b11;
    #1; push(1); push(0); push(0);
    pop_cmp("init_done_rerun", {63'd0, init_done});
    pop_cmp("x3_cleared", rdata[31:0]);
    pop_cmp("busy_reset", {63'd0, rbusy[1]});
    b_we = 1;
    for (int j = 0; j < 4; j++) begin
      b_waddr = ba[j]; b_wdata = bv[j];
      tick;
    end
    b_we = 0; b_re = 4'hF;
    for (int j = 0; j < 4; j++) begin
      b_raddr[j*4 +: 4] = ba[3-j];
      push(bv[3-j]);
    end
    #1;
    for (int j = 0; j < 4; j++) pop_cmp("b_port", b_rdata[j*64 +: 64]);
    b_we = 1; b_waddr = 4'd7; b_wdata = 64'h1111;
    tick;
    b_wdata = 64'hA5A5_A5A5; b_raddr[3:0] = 4'd7; b_re = 4'b0001;
    #1; push(64'h1111); pop_cmp("nobypass_old", b_rdata[63:0]);
    tick;
    b_we = 0;
    #1; push(64'hA5A5_A5A5); pop_cmp("nobypass_new", b_rdata[63:0]);
    b_iss_valid = 1; b_iss_rd = 4'd2; b_raddr[3:0] = 4'd2;
    tick;
    b_iss_valid = 0; b_we = 1; b_waddr = 4'd2;
    #1; push(1); pop_cmp("b_busy_no_bypass", {63'd0, b_rbusy[0]});
    tick;
    b_we = 0;
    #1; push(0); pop_cmp("b_busy_clr", {63'd0, b_rbusy[0]});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
